// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream width converters.
package axis_pkg;

    // Segment index width; never zero so RATIO=1 still yields a legal 1-bit index.
    function automatic int axis_seg_idx_w(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/axis_keep_last_seg.sv
// Priority encoder: index of the highest segment of a wide tkeep that has any byte enabled.
// Returns 0 when no keep bit is set at all.
module axis_keep_last_seg
    import axis_pkg::*;
#(
    parameter int RATIO        = 4,
    parameter int M_KEEP_WIDTH = 1
) (
    input  logic [M_KEEP_WIDTH*RATIO-1:0]     i_keep,
    output logic [axis_seg_idx_w(RATIO)-1:0]  o_last_seg
);

    localparam int SEG_W = axis_seg_idx_w(RATIO);

    logic [RATIO-1:0] w_seg_nz;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_seg_nz
            assign w_seg_nz[gi] = |i_keep[gi*M_KEEP_WIDTH +: M_KEEP_WIDTH];
        end
    endgenerate

    // Ascending scan: the last hit is the highest non-empty segment.
    always_comb begin
        o_last_seg = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (w_seg_nz[i]) begin
                o_last_seg = i[SEG_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_downsizer.sv
// Wide-to-narrow AXI4-Stream converter: each accepted beat is replayed as up to RATIO
// narrow beats, LSB segment first, trimming empty trailing segments of tlast beats.
module axis_downsizer
    import axis_pkg::*;
#(
    parameter int M_DATA_WIDTH = 8,
    parameter int RATIO        = 4,
    parameter int KEEP_ENABLE  = 1,
    parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
    parameter int LAST_ENABLE  = 1,
    parameter int ID_ENABLE    = 0,
    parameter int ID_WIDTH     = 8,
    parameter int DEST_ENABLE  = 0,
    parameter int DEST_WIDTH   = 8,
    parameter int USER_ENABLE  = 0,
    parameter int USER_WIDTH   = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,

    input  logic [M_DATA_WIDTH*RATIO-1:0]    s_axis_tdata,
    input  logic [M_KEEP_WIDTH*RATIO-1:0]    s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [ID_WIDTH-1:0]              s_axis_tid,
    input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,

    output logic [M_DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser
);

    localparam int S_DATA_WIDTH = M_DATA_WIDTH * RATIO;
    localparam int S_KEEP_WIDTH = M_KEEP_WIDTH * RATIO;
    localparam int SEG_W        = axis_seg_idx_w(RATIO);
    localparam logic [SEG_W-1:0] MAX_SEG = SEG_W'(RATIO - 1);

    // Held wide beat; deliberately not reset, qualified by r_valid.
    logic [S_DATA_WIDTH-1:0] r_data;
    logic [S_KEEP_WIDTH-1:0] r_keep;
    logic                    r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic [USER_WIDTH-1:0]   r_user;

    logic                    r_valid;
    logic [SEG_W-1:0]        r_seg_idx;
    logic [SEG_W-1:0]        r_last_seg;
    logic                    r_ready_en;

    logic                    w_in_last;
    logic [SEG_W-1:0]        w_enc_seg;
    logic [SEG_W-1:0]        w_new_last_seg;
    logic                    w_final_seg;
    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_m_xfer;

    logic [M_DATA_WIDTH-1:0] w_data_seg [RATIO];
    logic [M_KEEP_WIDTH-1:0] w_keep_seg [RATIO];

    axis_keep_last_seg #(
        .RATIO        (RATIO),
        .M_KEEP_WIDTH (M_KEEP_WIDTH)
    ) u_keep_last_seg (
        .i_keep     (s_axis_tkeep),
        .o_last_seg (w_enc_seg)
    );

    assign w_in_last      = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
    assign w_new_last_seg = ((KEEP_ENABLE != 0) && w_in_last) ? w_enc_seg : MAX_SEG;

    assign w_final_seg = (r_seg_idx == r_last_seg);
    // Accept a new beat in the same cycle the final segment leaves for full throughput.
    assign w_s_ready   = r_ready_en && (!r_valid || (m_axis_tready && w_final_seg));
    assign w_accept    = s_axis_tvalid && w_s_ready;
    assign w_m_xfer    = r_valid && m_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid    <= 1'b0;
            r_seg_idx  <= '0;
            r_last_seg <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_m_xfer) begin
                if (!w_final_seg) begin
                    r_seg_idx <= r_seg_idx + 1'b1;
                end else begin
                    r_seg_idx <= '0;
                    r_valid   <= 1'b0;
                end
            end
            if (w_accept) begin
                r_valid    <= 1'b1;
                r_seg_idx  <= '0;
                r_last_seg <= w_new_last_seg;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_data <= s_axis_tdata;
            r_keep <= s_axis_tkeep;
            r_last <= w_in_last;
            r_id   <= s_axis_tid;
            r_dest <= s_axis_tdest;
            r_user <= s_axis_tuser;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_seg
            assign w_data_seg[gi] = r_data[gi*M_DATA_WIDTH +: M_DATA_WIDTH];
            assign w_keep_seg[gi] = r_keep[gi*M_KEEP_WIDTH +: M_KEEP_WIDTH];
        end
    endgenerate

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = w_data_seg[r_seg_idx];
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? w_keep_seg[r_seg_idx] : {M_KEEP_WIDTH{1'b1}};
    assign m_axis_tlast  = (LAST_ENABLE != 0) ? (r_last && w_final_seg) : 1'b1;
    assign m_axis_tid    = (ID_ENABLE   != 0) ? r_id   : '0;
    assign m_axis_tdest  = (DEST_ENABLE != 0) ? r_dest : '0;
    assign m_axis_tuser  = (USER_ENABLE != 0) ? r_user : '0;

endmodule

// File: tb/tb_axis_downsizer.sv
// Self-checking bench for axis_downsizer (RATIO=4, 8-bit output, all sidebands enabled).
module tb_axis_downsizer;

    localparam int MW = 8;
    localparam int R  = 4;
    localparam int MK = 1;
    localparam int SW = MW * R;
    localparam int SK = MK * R;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [SW-1:0] s_tdata = '0;
    logic [SK-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [7:0]    s_tid = '0;
    logic [7:0]    s_tdest = '0;
    logic [0:0]    s_tuser = '0;
    logic [MW-1:0] m_tdata;
    logic [MK-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [7:0]    m_tid;
    logic [7:0]    m_tdest;
    logic [0:0]    m_tuser;

    always #5 aclk = ~aclk;

    axis_downsizer #(
        .M_DATA_WIDTH (MW),
        .RATIO        (R),
        .KEEP_ENABLE  (1),
        .M_KEEP_WIDTH (MK),
        .LAST_ENABLE  (1),
        .ID_ENABLE    (1),
        .ID_WIDTH     (8),
        .DEST_ENABLE  (1),
        .DEST_WIDTH   (8),
        .USER_ENABLE  (1),
        .USER_WIDTH   (1)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tid    (s_tid),
        .s_axis_tdest  (s_tdest),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tdest  (m_tdest),
        .m_axis_tuser  (m_tuser)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       last;
        logic [7:0] id;
        logic [7:0] dest;
        logic       user;
    } seg_t;

    seg_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    seg_t prev_out;
    bit   rand_done = 0;

    // Reference model: expected narrow beats for the wide beat currently on the input.
    function automatic void push_beat();
        int   hi;
        int   n;
        seg_t s;
        hi = 0;
        for (int i = 0; i < R; i++) begin
            if (s_tkeep[i]) hi = i;
        end
        n = s_tlast ? hi + 1 : R;
        for (int i = 0; i < n; i++) begin
            s.data = s_tdata[i*8 +: 8];
            s.keep = s_tkeep[i];
            s.last = s_tlast && (i == n - 1);
            s.id   = s_tid;
            s.dest = s_tdest;
            s.user = s_tuser[0];
            sb_q.push_back(s);
        end
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge aclk) begin
        seg_t g_seg;
        seg_t e_seg;
        g_seg = {m_tdata, m_tkeep[0], m_tlast, m_tid, m_tdest, m_tuser[0]};
        if (mon_en) begin
            if (prev_stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || g_seg !== prev_out) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%0b seg=%h, required valid=1 seg=%h",
                             m_tvalid, g_seg, prev_out);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got output seg=%h, required no output", g_seg);
                end else begin
                    e_seg = sb_q.pop_front();
                    if (g_seg !== e_seg) begin
                        errors++;
                        $display("FAIL sb_seg: got %h, required %h", g_seg, e_seg);
                    end
                end
            end
            if (s_tvalid && s_tready) push_beat();
            prev_stall = m_tvalid && !m_tready;
            prev_out   = g_seg;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic [7:0] id, input logic [7:0] dest, input logic u);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tid    = id;
        s_tdest  = dest;
        s_tuser  = u;
        s_tvalid = 1'b1;
    endtask

    // Holds the beat until accepted; returns the number of cycles it had to wait.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [7:0] id, input logic [7:0] dest, input logic u,
                             output int waited);
        bit hs;
        drive_beat(d, k, l, id, dest, u);
        waited = 0;
        hs = 0;
        while (!hs && waited < 100) begin
            @(negedge aclk);
            if (s_tready) hs = 1;
            else waited++;
            @(posedge aclk); #1;
        end
        s_tvalid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no handshake in %0d cycles, required accept", waited);
        end
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tkeep  = 4'hF;
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got s_tready=%0b m_tvalid=%0b, required 0 0",
                         s_tready, m_tvalid);
            end
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        aresetn  = 1'b1;
        mon_en   = 1;
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: got s_tready=%0b, required 0", s_tready);
        end
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got s_tready=%0b m_tvalid=%0b, required 1 0",
                     s_tready, m_tvalid);
        end
        @(posedge aclk); #1;
    endtask

    // Drives one beat into an idle DUT and checks the exact per-cycle output sequence.
    task automatic run_directed(input string name, input logic [31:0] d, input logic [3:0] k,
                                input logic l, input int nseg);
        logic [7:0] exp_d;
        m_tready = 1'b1;
        drive_beat(d, k, l, 8'h00, 8'h00, 1'b0);
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got s_tready=%0b, required 1", name, s_tready);
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        for (int i = 0; i < nseg; i++) begin
            @(negedge aclk);
            exp_d = d[i*8 +: 8];
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_d || m_tkeep[0] !== k[i] ||
                m_tlast !== (l && i == nseg - 1) || s_tready !== (i == nseg - 1)) begin
                errors++;
                $display("FAIL %s_seg%0d: got v=%0b d=%h k=%0b l=%0b rdy=%0b, required v=1 d=%h k=%0b l=%0b rdy=%0b",
                         name, i, m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready,
                         exp_d, k[i], (l && i == nseg - 1), (i == nseg - 1));
            end
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: got m_tvalid=%0b, required 0", name, m_tvalid);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        run_directed("basic", 32'h44332211, 4'hF, 1'b1, 4);
    endtask

    task automatic test_trim();
        run_directed("trim", 32'hDDCCBBAA, 4'h3, 1'b1, 2);
    endtask

    task automatic test_empty_last();
        run_directed("empty", 32'h12345678, 4'h0, 1'b1, 1);
    endtask

    task automatic test_null_seg();
        run_directed("nullseg", 32'h5A6B7C8D, 4'h3, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        int w;
        m_tready = 1'b1;
        send_beat(32'hA3A2A1A0, 4'hF, 1'b0, 8'h11, 8'h22, 1'b0, w);
        send_beat(32'h000000B0, 4'h1, 1'b1, 8'h33, 8'h44, 1'b1, w);
        checks++;
        if (w !== 3) begin
            errors++;
            $display("FAIL b2b_wait: got %0d cycles, required 3", w);
        end
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hB0 || m_tlast !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got v=%0b d=%h l=%0b, required v=1 d=b0 l=1",
                     m_tvalid, m_tdata, m_tlast);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got m_tvalid=%0b, required 0", m_tvalid);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        int          segx;
        int          cyc;
        logic [7:0]  exp_d;
        d = 32'h87654321;
        m_tready = 1'b1;
        drive_beat(d, 4'hF, 1'b1, 8'd5, 8'h00, 1'b1);
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        segx = 0;
        cyc  = 0;
        while (segx < 4 && cyc < 20) begin
            m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge aclk);
            exp_d = d[segx*8 +: 8];
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_d || m_tid !== 8'd5 || m_tuser !== 1'b1 ||
                s_tready !== (m_tready && segx == 3)) begin
                errors++;
                $display("FAIL bp_cyc%0d: got v=%0b d=%h id=%0d u=%0b rdy=%0b, required v=1 d=%h id=5 u=1 rdy=%0b",
                         cyc, m_tvalid, m_tdata, m_tid, m_tuser, s_tready, exp_d,
                         (m_tready && segx == 3));
            end
            if (m_tready) segx++;
            cyc++;
            @(posedge aclk); #1;
        end
        checks++;
        if (segx !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d segments, required 4", segx);
        end
        m_tready = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_random();
        int w;
        rand_done = 0;
        fork
            begin
                for (int b = 0; b < 1000; b++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge aclk); #1;
                    end
                    send_beat($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                              8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), w);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge aclk); #1;
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_tready = 1'b1;
        for (int i = 0; i < 50 && (sb_q.size() != 0 || m_tvalid); i++) begin
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        checks++;
        if (sb_q.size() != 0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got %0d pending, m_tvalid=%0b, required 0 pending, 0",
                     sb_q.size(), m_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trim();
        test_empty_last();
        test_null_seg();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- Converts a wide AXI4-Stream into a narrow one: each accepted input beat is split into RATIO output beats.
- Segments are emitted LSB segment first.
- A tlast-terminated beat whose upper segments have all-zero tkeep emits only up to its highest non-empty segment.
- Sits between wide datapath engines and narrow egress links (host DMA, network MAC), normally followed by a skid-buffer register slice.

Parameters:
- M_DATA_WIDTH, 8, output tdata width in bits; must be a multiple of 8 when KEEP_ENABLE=1.
- RATIO, 4, input/output width ratio; >=1; S_DATA_WIDTH = M_DATA_WIDTH*RATIO.
- KEEP_ENABLE, 1, propagate tkeep and enable trailing-segment trimming.
- M_KEEP_WIDTH, M_DATA_WIDTH/8, output tkeep width; S_KEEP_WIDTH = M_KEEP_WIDTH*RATIO.
- LAST_ENABLE, 1, propagate tlast; when 0, input tlast is treated as 1 and m_axis_tlast is driven 1.
- ID_ENABLE, 0 / ID_WIDTH, 8, tid pass-through.
- DEST_ENABLE, 0 / DEST_WIDTH, 8, tdest pass-through.
- USER_ENABLE, 0 / USER_WIDTH, 1, tuser pass-through, replicated on every segment.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous assert, active-low
- s_axis_tdata  in  S_DATA_WIDTH  wide input data
- s_axis_tkeep  in  S_KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of packet
- s_axis_tid / s_axis_tdest / s_axis_tuser  in  ID_WIDTH/DEST_WIDTH/USER_WIDTH  sideband
- m_axis_tdata  out  M_DATA_WIDTH  narrow output data
- m_axis_tkeep  out  M_KEEP_WIDTH  output byte enables; all ones when KEEP_ENABLE=0
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of packet
- m_axis_tid / m_axis_tdest / m_axis_tuser  out  as input  sideband; zero when the corresponding enable is 0

Behaviour:
- State: held wide beat (data, keep, last, id, dest, user); valid_reg; seg_idx [clog2(RATIO)]; last_seg [clog2(RATIO)]; ready_en.
- Reset (aresetn low, asynchronous): valid_reg=0, seg_idx=0, last_seg=0, ready_en=0. Outputs during reset: m_axis_tvalid=0, s_axis_tready=0. Data registers are not reset.
- ready_en is set to 1 on the first aclk edge after aresetn deasserts.
- s_axis_tready = ready_en && (!valid_reg || (m_axis_tready && seg_idx==last_seg)).
  - This is the only combinational ready-to-ready path.
  - It gives full throughput: a new beat is accepted in the same cycle the final segment of the current beat transfers.
- Accept (s_axis_tvalid && s_axis_tready):
  - Latch the beat; seg_idx<=0; valid_reg<=1.
  - last_seg <= (KEEP_ENABLE && tlast) ? index of the highest segment with any tkeep bit set : RATIO-1.
  - If a tlast beat has all-zero tkeep, last_seg=0: one segment is emitted with tkeep=0 and tlast=1, so framing is preserved.
- Output transfer (m_axis_tvalid && m_axis_tready):
  - If seg_idx!=last_seg: seg_idx++.
  - Else: seg_idx<=0; valid_reg<=0, unless an accept occurs in the same cycle, in which case valid_reg stays 1 with the new beat.
- Output datapath:
  - m_axis_tvalid = valid_reg.
  - m_axis_tdata / m_axis_tkeep = segment seg_idx of the held beat.
  - m_axis_tlast = held_last && (seg_idx==last_seg).
  - tid/tdest/tuser = held values.
- Non-tlast beats always emit all RATIO segments; null segments (tkeep=0) pass through.
- Latency: first segment is valid on the cycle after acceptance. Sustained input rate is 1 beat per (last_seg+1) cycles.
- Output stability: while m_axis_tvalid && !m_axis_tready, all m_axis signals hold stable (AXI rule).
- RATIO=1: seg_idx is constant 0; the block behaves as a single-stage pipeline register with a combinational ready path.
- Reset mid-packet: the held beat is discarded and no partial tlast is generated. Upstream is responsible for resynchronising framing.

Decomposition:
- Shared package axis_pkg: function axis_seg_idx_w(ratio) returning max(1, clog2(ratio)). No typedefs; ports stay flat vectors for tool compatibility.
- One sub-module: axis_keep_last_seg. Combinational priority encoder that takes S_KEEP_WIDTH keep bits and returns the highest non-zero segment index. It is reused by the planned upsizer.

Test Plan:
- Reset: hold aresetn=0 for 5 cycles with s_axis_tvalid=1 -> s_axis_tready=0 and m_axis_tvalid=0 throughout; s_axis_tready=1 on the first cycle after the first post-release edge.
- Basic split (RATIO=4, M_DATA_WIDTH=8): beat tdata=0x44332211, tkeep=0xF, tlast=1, m_axis_tready=1 -> output beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; tlast only on 0x44; next input accepted in the 0x44 cycle.
- Trim: tdata=0xDDCCBBAA, tkeep=0x3, tlast=1 -> output beats 0xAA, 0xBB only; tlast on 0xBB; 2-cycle occupancy.
- Empty last beat: tkeep=0x0, tlast=1 -> one output beat with tkeep=0, tlast=1.
- Non-last null segment: tkeep=0x3, tlast=0 -> all 4 segments emitted; segments 2 and 3 have tkeep=0; tlast=0 on all.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-segment beat with tuser=1, tid=5 -> segments in order; each output stable while stalled; tuser=1 and tid=5 on all four; s_axis_tready low until the final transfer; no beat lost or duplicated over 1000 random beats (scoreboard).
